// File: rtl/ifetch_pkg.sv
// ----------------------------------------------------------------------------
// ifetch_pkg
// Shared constants for the instruction-fetch sequencer:
//   ADDR_W / DATA_W   - address and instruction word widths
//   S_RUN/S_HALT/S_FAULT - fetch FSM state encodings (state_t)
//   NOP_WORD_DEF      - default bubble instruction for an empty IF/ID slot
// ----------------------------------------------------------------------------
package ifetch_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;

    typedef logic [1:0] state_t;

    localparam state_t S_RUN   = 2'd0;
    localparam state_t S_HALT  = 2'd1;
    localparam state_t S_FAULT = 2'd2;

    localparam logic [DATA_W-1:0] NOP_WORD_DEF = 32'h0000_0000;

    // A byte address is fetchable when it lies inside the word-addressed memory.
    function automatic logic addr_in_range(input logic [ADDR_W-1:0] addr,
                                           input logic [ADDR_W-1:0] limit);
        return (addr < limit);
    endfunction

endpackage

// File: rtl/instr_fetch_ctrl_ifid_reg.sv
// ----------------------------------------------------------------------------
// ifid_reg
// IF/ID pipeline register. Priority: reset > flush > load > hold.
//   i_clk, i_rst      - clock, asynchronous active-high reset
//   i_load            - capture i_instr / i_pc as a valid instruction
//   i_flush           - invalidate the slot (instr becomes NOP_WORD, pc held)
//   i_instr, i_pc     - instruction word and its byte address
//   o_valid, o_instr, o_pc, o_pc_plus4 - registered slot contents
// ----------------------------------------------------------------------------
module ifid_reg
    import ifetch_pkg::*;
#(
    parameter logic [DATA_W-1:0] NOP_WORD = NOP_WORD_DEF
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_load,
    input  logic              i_flush,
    input  logic [DATA_W-1:0] i_instr,
    input  logic [ADDR_W-1:0] i_pc,
    output logic              o_valid,
    output logic [DATA_W-1:0] o_instr,
    output logic [ADDR_W-1:0] o_pc,
    output logic [ADDR_W-1:0] o_pc_plus4
);

    logic              r_valid;
    logic [DATA_W-1:0] r_instr;
    logic [ADDR_W-1:0] r_pc;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_valid <= 1'b0;
            r_instr <= NOP_WORD;
            r_pc    <= '0;
        end else if (i_flush) begin
            r_valid <= 1'b0;
            r_instr <= NOP_WORD;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_instr <= i_instr;
            r_pc    <= i_pc;
        end
    end

    assign o_valid    = r_valid;
    assign o_instr    = r_instr;
    assign o_pc       = r_pc;
    assign o_pc_plus4 = r_pc + 32'd4;

endmodule

// File: rtl/instr_fetch_ctrl.sv
// ----------------------------------------------------------------------------
// instr_fetch_ctrl
// Instruction-fetch sequencer: owns the PC, addresses a combinational-read
// instruction memory and fills the IF/ID register. Handles stalls,
// redirects, halt/resume and sticky faults (misaligned redirect or
// out-of-range fetch).
//   Clk, Reset        - clock, asynchronous active-high reset
//   imem_addr         - byte address to memory (straight from PC register)
//   imem_instr        - instruction returned in the same cycle
//   stall             - hold PC, IF/ID and count
//   redirect_valid/_target - branch/jump redirect (wins over stall)
//   halt_req, resume  - stop / restart fetching
//   if_valid, if_instr, if_pc, if_pc_plus4 - IF/ID contents
//   halted, fault     - state flags
//   fetch_count       - instructions captured into IF/ID (wraps)
// ----------------------------------------------------------------------------
module instr_fetch_ctrl
    import ifetch_pkg::*;
#(
    parameter int unsigned       IMEM_DEPTH = 128,
    parameter logic [ADDR_W-1:0] RESET_PC   = 32'h0000_0000,
    parameter logic [DATA_W-1:0] NOP_WORD   = NOP_WORD_DEF
) (
    input  logic              Clk,
    input  logic              Reset,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [DATA_W-1:0] imem_instr,
    input  logic              stall,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_target,
    input  logic              halt_req,
    input  logic              resume,
    output logic              if_valid,
    output logic [DATA_W-1:0] if_instr,
    output logic [ADDR_W-1:0] if_pc,
    output logic [ADDR_W-1:0] if_pc_plus4,
    output logic              halted,
    output logic              fault,
    output logic [31:0]       fetch_count
);

    localparam logic [ADDR_W-1:0] PC_LIMIT = ADDR_W'(IMEM_DEPTH * 4);

    state_t            r_state;
    logic [ADDR_W-1:0] r_pc;
    logic [31:0]       r_fetch_count;

    state_t            w_next_state;
    logic [ADDR_W-1:0] w_next_pc;
    logic              w_load;
    logic              w_flush;
    logic              w_misaligned;

    assign w_misaligned = (redirect_target[1:0] != 2'b00);

    // Priority: FAULT hold > redirect > halt_req > stall > fetch.
    always_comb begin
        w_next_state = r_state;
        w_next_pc    = r_pc;
        w_load       = 1'b0;
        w_flush      = 1'b0;
        case (r_state)
            S_RUN: begin
                if (redirect_valid) begin
                    w_next_pc = redirect_target;
                    w_flush   = 1'b1;
                    if (w_misaligned) w_next_state = S_FAULT;
                end else if (halt_req) begin
                    w_next_state = S_HALT;
                    w_flush      = 1'b1;
                end else if (!stall) begin
                    if (addr_in_range(r_pc, PC_LIMIT)) begin
                        w_next_pc = r_pc + 32'd4;
                        w_load    = 1'b1;
                    end else begin
                        w_next_state = S_FAULT;
                        w_flush      = 1'b1;
                    end
                end
            end
            S_HALT: begin
                // A redirect while halted only moves the PC; resume that
                // same cycle is outranked and the block stays halted.
                if (redirect_valid) begin
                    w_next_pc = redirect_target;
                    w_flush   = 1'b1;
                    if (w_misaligned) w_next_state = S_FAULT;
                end else if (resume) begin
                    w_next_state = S_RUN;
                end
            end
            default: begin
                // FAULT (and the unused encoding) freeze everything.
            end
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_state       <= S_RUN;
            r_pc          <= RESET_PC;
            r_fetch_count <= '0;
        end else begin
            r_state <= w_next_state;
            r_pc    <= w_next_pc;
            if (w_load) r_fetch_count <= r_fetch_count + 32'd1;
        end
    end

    ifid_reg #(
        .NOP_WORD (NOP_WORD)
    ) u_ifid (
        .i_clk      (Clk),
        .i_rst      (Reset),
        .i_load     (w_load),
        .i_flush    (w_flush),
        .i_instr    (imem_instr),
        .i_pc       (r_pc),
        .o_valid    (if_valid),
        .o_instr    (if_instr),
        .o_pc       (if_pc),
        .o_pc_plus4 (if_pc_plus4)
    );

    assign imem_addr   = r_pc;
    assign halted      = (r_state == S_HALT);
    assign fault       = (r_state == S_FAULT);
    assign fetch_count = r_fetch_count;

endmodule

// File: doc/instr_fetch_ctrl.md
Name: instr_fetch_ctrl

Overview:
Instruction-fetch sequencer for the MIPS pipeline. It owns the program counter and drives the word address into the 128-word combinational-read instruction memory. It captures the returned instruction into the IF/ID pipeline register. It handles hazard stalls, branch/jump redirects, halt/resume and out-of-range or misaligned fetch faults.

Parameters:
IMEM_DEPTH, 128, instruction memory size in words; the legal byte-address range is 0 to IMEM_DEPTH*4-4.
RESET_PC, 32'h0000_0000, PC value loaded on reset; must be word-aligned.
NOP_WORD, 32'h0000_0000, value driven on if_instr whenever the IF/ID slot is invalid.

Ports:
Clk  input  1  system clock, rising-edge.
Reset  input  1  asynchronous, active-high reset.
imem_addr  output  32  byte address to instruction memory; combinationally equal to PC.
imem_instr  input  32  instruction word returned by memory in the same cycle.
stall  input  1  hazard unit freeze: hold PC and IF/ID.
redirect_valid  input  1  taken branch/jump from a later stage.
redirect_target  input  32  new PC byte address when redirect_valid is high.
halt_req  input  1  pulse: stop fetching.
resume  input  1  pulse: restart fetching from the current PC.
if_valid  output  1  IF/ID holds a real instruction.
if_instr  output  32  IF/ID instruction, or NOP_WORD when invalid.
if_pc  output  32  IF/ID instruction address.
if_pc_plus4  output  32  if_pc + 4.
halted  output  1  state is HALT.
fault  output  1  state is FAULT (sticky).
fetch_count  output  32  number of instructions captured into IF/ID.

Behaviour:
- Reset (asynchronous, any time, including mid-stall or mid-redirect) forces the following immediately:
  - PC = RESET_PC, state = RUN.
  - if_valid = 0, if_instr = NOP_WORD, if_pc = 0, if_pc_plus4 = 4.
  - halted = 0, fault = 0, fetch_count = 0.
- States: RUN, HALT, FAULT. Encoding is defined in the package.
- Same-cycle priority, per rising edge: FAULT hold > redirect > halt_req > stall > normal fetch.
- RUN, normal fetch (no redirect, no halt_req, stall = 0, PC in range):
  - PC <= PC + 4.
  - IF/ID <= {valid = 1, imem_instr, PC}.
  - fetch_count <= fetch_count + 1. The counter wraps modulo 2^32.
  - Latency: the instruction at address A appears on if_instr one cycle after imem_addr = A.
- RUN with stall = 1: PC, IF/ID and fetch_count all hold.
- Redirect in RUN, which takes effect even if stall = 1:
  - PC <= redirect_target.
  - if_valid <= 0 and if_instr <= NOP_WORD, flushing the wrong-path fetch.
  - fetch_count is unchanged.
- Misaligned redirect (redirect_target[1:0] != 0): go to FAULT, PC <= redirect_target, if_valid <= 0.
- Out-of-range fetch: in RUN with stall = 0 and no redirect, if PC >= IMEM_DEPTH*4, go to FAULT.
  - PC is frozen and if_valid <= 0.
  - The check happens only on an actual fetch attempt. PC = IMEM_DEPTH*4 while stalled does not fault.
- halt_req in RUN (no redirect): go to HALT, PC held, if_valid <= 0.
- HALT behaviour:
  - No fetch and no count.
  - A redirect updates PC but the block stays in HALT.
  - resume returns to RUN; fetching restarts the next cycle from PC.
  - halt_req in HALT is ignored. resume in RUN or FAULT is ignored.
  - If halt_req and resume are asserted together, halt_req wins in RUN and resume wins in HALT.
- FAULT is sticky until Reset. PC and IF/ID are frozen, if_valid = 0, and all inputs are ignored.
- Arithmetic: PC + 4 is 32-bit and wraps. The wrapped value is still caught by the range check.
- imem_addr is driven straight from the PC register with no combinational path from inputs. The memory itself ignores bits [1:0].

Decomposition:
- Package ifetch_pkg holds:
  - state typedef/localparams (RUN = 2'd0, HALT = 2'd1, FAULT = 2'd2);
  - NOP_WORD default;
  - width constant ADDR_W = 32.
- One sub-module, ifid_reg: the IF/ID pipeline register with load, flush and hold controls. It holds valid, instr and pc, and derives pc_plus4.
- PC register, FSM and fetch counter stay in the top module.

Test Plan:
- Bench memory returns index*3 per word. Reset, then run 4 cycles → if_pc 0, 4, 8, 12 with if_instr 0, 3, 6, 9; fetch_count = 4.
- stall held 3 cycles at PC = 8 → imem_addr stays 8, if_instr stays 3, fetch_count unchanged; release → if_instr = 6.
- redirect_valid with target 0x40 and stall = 1 in the same cycle → next cycle if_valid = 0, imem_addr = 0x40; the following cycle if_instr = 48 (0x30), if_pc = 0x40.
- halt_req, then redirect to 0x10 while halted, then resume → halted = 1 with no count change during HALT; after resume if_instr = 12, if_pc = 0x10.
- Redirect to 0x1FC and run → if_instr = 381; next fetch at 0x200 → fault = 1, if_valid = 0, PC frozen at 0x200. A later resume or redirect has no effect.
- Redirect to 0x42 → fault = 1. Assert Reset asynchronously mid-cycle → outputs return to reset values immediately and fetching resumes from RESET_PC after deassertion.
